// File: rtl/seg_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler_if
//
// Write-request bundle shared by the two requesters (A and B) of the
// seven-segment scan scheduler.
//
// Signals (per requester x in {a, b}):
//   x_valid : requester has a write pending
//   x_idx   : target digit index 0..7
//   x_data  : {enable, hex[3:0]}
//   x_ready : combinational grant from the scheduler
//
// Modports:
//   master : requester side (drives valid/idx/data, observes ready)
//   slave  : scheduler side (observes valid/idx/data, drives ready)
// ---------------------------------------------------------------------------
interface seg_scan_scheduler_if;
  logic       a_valid;
  logic [2:0] a_idx;
  logic [4:0] a_data;
  logic       a_ready;

  logic       b_valid;
  logic [2:0] b_idx;
  logic [4:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_idx, a_data,
    output b_valid, b_idx, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_idx, a_data,
    input  b_valid, b_idx, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler
//
// Time-multiplexing controller for an 8-digit common-anode seven-segment
// display. Holds a per-digit buffer of {enable, hex} entries, scans one digit
// per SCAN_DIV cycles and blanks the first GUARD cycles of every slot to
// avoid ghosting. Two requesters share buffer write access through a
// round-robin arbiter with a valid/ready handshake.
//
// Parameters:
//   SCAN_DIV : cycles each digit is selected (4..65536)
//   GUARD    : blank cycles at the start of each slot (1..SCAN_DIV-1)
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   bus        : write-request interface (slave modport)
//   an         : digit selects, active-low, registered
//   gout       : segments {a,b,c,d,e,f,g}, active-low, registered
//   frame_tick : one-cycle pulse on the digit 7 -> digit 0 wrap, registered
// ---------------------------------------------------------------------------
module seg_scan_scheduler #(
  parameter int SCAN_DIV = 1024,
  parameter int GUARD    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_scheduler_if.slave   bus,
  output logic [7:0]            an,
  output logic [6:0]            gout,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_V = CW'(GUARD);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t         prio_q, prio_next;
  logic [CW-1:0] cnt_q, cnt_next;
  logic [2:0]    ptr_q, ptr_next;
  logic [4:0]    digit_q [8];

  logic          a_grant, b_grant;
  logic          wr_en;
  logic [2:0]    wr_idx;
  logic [4:0]    wr_data;
  logic [4:0]    disp_entry;
  logic          blank;
  logic          tick_next;
  logic [7:0]    an_next;
  logic [6:0]    gout_next;

  // Active-low hex font for segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0001100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b1110010;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Round-robin grant: when both requesters are valid the one named by prio
  // wins; a lone requester is granted regardless of prio.
  assign a_grant = bus.a_valid & (~bus.b_valid | (prio_q == PRIO_A));
  assign b_grant = bus.b_valid & (~bus.a_valid | (prio_q == PRIO_B));
  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // Priority next-state and the single buffer write port selected by grant.
  always_comb begin
    prio_next = prio_q;
    wr_en     = 1'b0;
    wr_idx    = bus.a_idx;
    wr_data   = bus.a_data;
    if (a_grant) begin
      prio_next = PRIO_B;
      wr_en     = 1'b1;
    end else if (b_grant) begin
      prio_next = PRIO_A;
      wr_en     = 1'b1;
      wr_idx    = bus.b_idx;
      wr_data   = bus.b_data;
    end
  end

  // Prescaler and scan pointer; the 3-bit pointer wraps naturally 7 -> 0.
  always_comb begin
    cnt_next  = cnt_q + CW'(1);
    ptr_next  = ptr_q;
    tick_next = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_next  = '0;
      ptr_next  = ptr_q + 3'd1;
      tick_next = (ptr_q == 3'd7);
    end
  end

  // Display decode works on post-edge state, so a write to the digit being
  // shown bypasses the buffer and appears on the same edge it is stored.
  always_comb begin
    disp_entry = digit_q[ptr_next];
    if (wr_en && (wr_idx == ptr_next)) begin
      disp_entry = wr_data;
    end
    blank     = (cnt_next < GUARD_V) || !disp_entry[4];
    an_next   = 8'hFF;
    gout_next = 7'h7F;
    if (!blank) begin
      an_next   = ~(8'b1 << ptr_next);
      gout_next = font(disp_entry[3:0]);
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      prio_q     <= PRIO_A;
      an         <= 8'hFF;
      gout       <= 7'h7F;
      frame_tick <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_next;
      ptr_q      <= ptr_next;
      prio_q     <= prio_next;
      an         <= an_next;
      gout       <= gout_next;
      frame_tick <= tick_next;
      if (wr_en) begin
        digit_q[wr_idx] <= wr_data;
      end
    end
  end

endmodule
